// File: rtl/yarvi_trace_pkg.sv
// Shared definitions for the retirement trace buffer: record layout, stream word-0 layout, drain states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package yarvi_trace_pkg;

    // Core address / data widths; both must stay <= 31 so the 32-bit stream words can carry them.
    localparam int VMSB = 31;
    localparam int XMSB = 31;

    // Stream word 0 layout: {tag[31:30], priv[29:28], drop[27], rd[26:22], 6'b0, seq[15:0]}
    localparam logic [1:0] TRACE_TAG   = 2'b10;
    localparam int         W0_TAG_LSB  = 30;
    localparam int         W0_PRIV_LSB = 28;
    localparam int         W0_DROP_BIT = 27;
    localparam int         W0_RD_LSB   = 22;
    localparam int         W0_SEQ_LSB  = 0;

    localparam int REC_W = 32 + 32 + 32 + 2 + 5 + 1 + 16;
    localparam int BEATS = 4;

    typedef struct packed {
        logic [15:0] seq;
        logic        drop;
        logic [1:0]  priv;
        logic [4:0]  rd;
        logic [31:0] pc;
        logic [31:0] insn;
        logic [31:0] val;
    } rec_t;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } drain_st_e;

    function automatic logic [31:0] trace_word0(input rec_t r);
        logic [31:0] w;
        w                        = '0;
        w[W0_TAG_LSB +: 2]       = TRACE_TAG;
        w[W0_PRIV_LSB +: 2]      = r.priv;
        w[W0_DROP_BIT]           = r.drop;
        w[W0_RD_LSB +: 5]        = r.rd;
        w[W0_SEQ_LSB +: 16]      = r.seq;
        return w;
    endfunction

endpackage

// File: rtl/yarvi_trace_if.sv
// Bundles the core retirement bus (me_*) and the host trace stream (tr_*).
// Latency: n/a (wires only).
// Backpressure: tr_ready from the sink; slave = trace block, master = core/host side.
interface yarvi_trace_if;
    import yarvi_trace_pkg::*;

    logic            me_valid;
    logic [1:0]      me_priv;
    logic [VMSB:0]   me_pc;
    logic [31:0]     me_insn;
    logic [4:0]      me_wb_rd;
    logic [XMSB:0]   me_wb_val;

    logic            tr_valid;
    logic [31:0]     tr_data;
    logic            tr_last;
    logic            tr_ready;

    modport master (
        output me_valid, me_priv, me_pc, me_insn, me_wb_rd, me_wb_val, tr_ready,
        input  tr_valid, tr_data, tr_last
    );

    modport slave (
        input  me_valid, me_priv, me_pc, me_insn, me_wb_rd, me_wb_val, tr_ready,
        output tr_valid, tr_data, tr_last
    );
endinterface

// File: rtl/yarvi_trace_fifo.sv
// Single-clock record FIFO with a registered head word; ports push/pop/din/dout/count.
// Latency: a push into an empty FIFO appears on dout the next cycle.
// Backpressure: none internally; caller must not push when full unless popping in the same cycle.
module yarvi_trace_fifo #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  push,
    input  logic                  pop,
    input  logic [WIDTH-1:0]      din,
    output logic [WIDTH-1:0]      dout,
    output logic [DEPTH_LOG2:0]   count
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [WIDTH-1:0]       mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, rd_nxt;
    logic [DEPTH_LOG2:0]    count_q, count_d;
    logic [WIDTH-1:0]       head_q, head_d;

    always_comb begin
        rd_nxt   = rd_ptr_q + 1'b1;
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_nxt          : rd_ptr_q;

        count_d = count_q;
        if (push && !pop)      count_d = count_q + 1'b1;
        else if (pop && !push) count_d = count_q - 1'b1;

        // Head is kept in a register so the stream mux never reads the array directly.
        // On pop the successor is either already in the array or is the word being pushed now.
        head_d = head_q;
        if (pop) begin
            head_d = (count_q[DEPTH_LOG2:1] != '0) ? mem_q[rd_nxt] : din;
        end else if (push && (count_q == '0)) begin
            head_d = din;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
            if (push) mem_q[wr_ptr_q] <= din;
        end
    end

    assign dout  = head_q;
    assign count = count_q;
endmodule

// File: rtl/yarvi_trace.sv
// Retirement trace buffer: captures retired instructions, streams each as 4 x 32-bit words (w0 hdr, pc, insn, val).
// Latency: record visible on tr_valid one cycle after it is stored; records stream back-to-back.
// Backpressure: tr_ready stalls the stream; freeze stalls the core when free slots <= FREEZE_MARGIN; excess retirements dropped and counted.
module yarvi_trace
    import yarvi_trace_pkg::*;
#(
    parameter int DEPTH_LOG2    = 4,
    parameter int FREEZE_MARGIN = 3
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 enable,
    yarvi_trace_if.slave         tr,
    output logic                 freeze,
    output logic                 overflow,
    output logic [15:0]          drop_count,
    output logic [DEPTH_LOG2:0]  level
);
    localparam int                  DEPTH   = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] DEPTH_L = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0] FRZ_TH  = (DEPTH_LOG2 + 1)'(DEPTH - FREEZE_MARGIN);

    drain_st_e           state_q, state_d;
    logic [1:0]          beat_q, beat_d;
    logic                vld_q, vld_d;
    logic [15:0]         seq_q, seq_d;
    logic                pend_q, pend_d;
    logic                ovf_q, ovf_d;
    logic [15:0]         drops_q, drops_d;
    logic                frz_q, frz_d;

    logic                cap, hs, pop, push;
    logic [DEPTH_LOG2:0] level_d;
    rec_t                rec_in, head;
    logic [31:0]         beat_word;

    yarvi_trace_fifo #(
        .WIDTH      (REC_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (rec_in),
        .dout  (head),
        .count (level)
    );

    always_comb begin
        cap  = enable & tr.me_valid;
        hs   = vld_q & tr.tr_ready;
        pop  = hs & (beat_q == 2'd3);
        // A full FIFO still accepts when the head leaves in the same cycle.
        push = cap & ((level < DEPTH_L) | pop);

        level_d = level;
        if (push && !pop)      level_d = level + 1'b1;
        else if (pop && !push) level_d = level - 1'b1;

        rec_in      = '0;
        rec_in.seq  = seq_q;
        rec_in.drop = pend_q;
        rec_in.priv = tr.me_priv;
        rec_in.rd   = tr.me_wb_rd;
        rec_in.pc   = 32'(tr.me_pc);
        rec_in.insn = tr.me_insn;
        rec_in.val  = 32'(tr.me_wb_val);

        seq_d   = cap ? seq_q + 1'b1 : seq_q;
        pend_d  = pend_q;
        ovf_d   = ovf_q;
        drops_d = drops_q;
        if (push) begin
            pend_d = 1'b0;
        end else if (cap) begin
            pend_d  = 1'b1;
            ovf_d   = 1'b1;
            drops_d = (drops_q == 16'hFFFF) ? drops_q : drops_q + 1'b1;
        end

        state_d = state_q;
        beat_d  = beat_q;
        case (state_q)
            S_IDLE: if (level != '0) state_d = S_SEND;
            S_SEND: if (hs) begin
                beat_d = beat_q + 1'b1;
                if (pop && (level_d == '0)) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        vld_d = (state_d == S_SEND);

        frz_d = enable & (level_d >= FRZ_TH);

        case (beat_q)
            2'd0:    beat_word = trace_word0(head);
            2'd1:    beat_word = head.pc;
            2'd2:    beat_word = head.insn;
            default: beat_word = head.val;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= S_IDLE;
            beat_q  <= 2'd0;
            vld_q   <= 1'b0;
            seq_q   <= '0;
            pend_q  <= 1'b0;
            ovf_q   <= 1'b0;
            drops_q <= '0;
            frz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            vld_q   <= vld_d;
            seq_q   <= seq_d;
            pend_q  <= pend_d;
            ovf_q   <= ovf_d;
            drops_q <= drops_d;
            frz_q   <= frz_d;
        end
    end

    // Head and beat only move on a handshake, so the word is stable while stalled.
    assign tr.tr_valid = vld_q;
    assign tr.tr_data  = vld_q ? beat_word : 32'h0;
    assign tr.tr_last  = vld_q & (beat_q == 2'd3);
    assign freeze      = frz_q;
    assign overflow    = ovf_q;
    assign drop_count  = drops_q;
endmodule

// File: tb/tb_yarvi_trace.sv
// Self-checking bench for yarvi_trace: vector table for single-record / stall / enable cases,
// hand sequences for fill-and-drop, full with simultaneous pop, and reset mid-record.
module tb_yarvi_trace;
    import yarvi_trace_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        enable;
    logic        freeze, overflow;
    logic [15:0] drop_count;
    logic [4:0]  level;

    yarvi_trace_if bus ();

    yarvi_trace #(.DEPTH_LOG2(4), .FREEZE_MARGIN(3)) dut (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .tr         (bus),
        .freeze     (freeze),
        .overflow   (overflow),
        .drop_count (drop_count),
        .level      (level)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        en, mv;
        logic [1:0]  priv;
        logic [31:0] pc, insn;
        logic [4:0]  rd;
        logic [31:0] val;
        logic        rdy;
        logic        e_vld;
        logic [31:0] e_dat;
        logic        e_last;
        logic [4:0]  e_lvl;
        logic        e_frz;
    } vec_t;

    vec_t        vt[$];
    logic [31:0] wq[$];
    logic        lq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drv(input logic en, input logic mv, input logic [1:0] pr, input logic [31:0] pc,
                       input logic [31:0] insn, input logic [4:0] rd, input logic [31:0] val, input logic rdy);
        enable        = en;
        bus.me_valid  = mv;
        bus.me_priv   = pr;
        bus.me_pc     = pc;
        bus.me_insn   = insn;
        bus.me_wb_rd  = rd;
        bus.me_wb_val = val;
        bus.tr_ready  = rdy;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        drv(1, 0, 0, 0, 0, 0, 0, 0);
        step();
        step();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        // ---------------- reset state ----------------
        do_reset();
        chk("rst_valid", 32'(bus.tr_valid), 0);
        chk("rst_data", bus.tr_data, 0);
        chk("rst_last", 32'(bus.tr_last), 0);
        chk("rst_freeze", 32'(freeze), 0);
        chk("rst_overflow", 32'(overflow), 0);
        chk("rst_drops", 32'(drop_count), 0);
        chk("rst_level", 32'(level), 0);
        reset = 1'b1;

        // ---------------- vector table ----------------
        // single retire (seq 0)
        vt.push_back('{1,1,2'd3,32'h80000000,32'h00500093,5'd1,32'h5,1, 0,32'h0,0,5'd1,0});
        vt.push_back('{1,0,2'd0,32'h0,32'h0,5'd0,32'h0,1,        1,32'hB0400000,0,5'd1,0});
        vt.push_back('{1,0,2'd0,32'h0,32'h0,5'd0,32'h0,1,        1,32'h80000000,0,5'd1,0});
        vt.push_back('{1,0,2'd0,32'h0,32'h0,5'd0,32'h0,1,        1,32'h00500093,0,5'd1,0});
        vt.push_back('{1,0,2'd0,32'h0,32'h0,5'd0,32'h0,1,        1,32'h00000005,1,5'd1,0});
        vt.push_back('{1,0,2'd0,32'h0,32'h0,5'd0,32'h0,1,        0,32'h0,0,5'd0,0});
        // stall during the pc beat (seq 1)
        vt.push_back('{1,1,2'd0,32'h1000,32'h13,5'd0,32'h0,0,    0,32'h0,0,5'd1,0});
        vt.push_back('{1,0,2'd0,32'h0,32'h0,5'd0,32'h0,0,        1,32'h80000001,0,5'd1,0});
        vt.push_back('{1,0,2'd0,32'h0,32'h0,5'd0,32'h0,1,        1,32'h1000,0,5'd1,0});
        vt.push_back('{1,0,2'd0,32'h0,32'h0,5'd0,32'h0,0,        1,32'h1000,0,5'd1,0});
        vt.push_back('{1,0,2'd0,32'h0,32'h0,5'd0,32'h0,0,        1,32'h1000,0,5'd1,0});
        vt.push_back('{1,0,2'd0,32'h0,32'h0,5'd0,32'h0,1,        1,32'h13,0,5'd1,0});
        vt.push_back('{1,0,2'd0,32'h0,32'h0,5'd0,32'h0,1,        1,32'h0,1,5'd1,0});
        vt.push_back('{1,0,2'd0,32'h0,32'h0,5'd0,32'h0,1,        0,32'h0,0,5'd0,0});
        // enable low: retirements ignored
        for (int k = 0; k < 5; k++)
            vt.push_back('{0,1,2'd0,32'h4,32'h5,5'd2,32'h7,1,    0,32'h0,0,5'd0,0});
        // re-enabled: seq continues at 2
        vt.push_back('{1,1,2'd1,32'h2000,32'h33,5'd31,32'hDEADBEEF,1, 0,32'h0,0,5'd1,0});
        vt.push_back('{1,0,2'd0,32'h0,32'h0,5'd0,32'h0,1,        1,32'h97C00002,0,5'd1,0});
        vt.push_back('{1,0,2'd0,32'h0,32'h0,5'd0,32'h0,1,        1,32'h2000,0,5'd1,0});
        vt.push_back('{1,0,2'd0,32'h0,32'h0,5'd0,32'h0,1,        1,32'h33,0,5'd1,0});
        vt.push_back('{1,0,2'd0,32'h0,32'h0,5'd0,32'h0,1,        1,32'hDEADBEEF,1,5'd1,0});
        vt.push_back('{1,0,2'd0,32'h0,32'h0,5'd0,32'h0,1,        0,32'h0,0,5'd0,0});

        for (int k = 0; k < vt.size(); k++) begin
            drv(vt[k].en, vt[k].mv, vt[k].priv, vt[k].pc, vt[k].insn, vt[k].rd, vt[k].val, vt[k].rdy);
            step();
            chk($sformatf("vec%0d_valid", k), 32'(bus.tr_valid), 32'(vt[k].e_vld));
            chk($sformatf("vec%0d_data", k),  bus.tr_data,       vt[k].e_dat);
            chk($sformatf("vec%0d_last", k),  32'(bus.tr_last),  32'(vt[k].e_last));
            chk($sformatf("vec%0d_level", k), 32'(level),        32'(vt[k].e_lvl));
            chk($sformatf("vec%0d_freeze", k), 32'(freeze),      32'(vt[k].e_frz));
        end

        // ---------------- fill with sink stalled, then drop ----------------
        do_reset();
        reset = 1'b1;
        for (int i = 0; i < 16; i++) begin
            drv(1, 1, 0, 32'h100 + 32'(i), 32'(i), 0, 32'(i), 0);
            step();
            chk($sformatf("fill%0d_level", i), 32'(level), 32'(i + 1));
            chk($sformatf("fill%0d_freeze", i), 32'(freeze), (i + 1 >= 13) ? 32'd1 : 32'd0);
        end
        drv(1, 1, 0, 32'h110, 32'h10, 0, 32'h10, 0);
        step();
        chk("drop_level", 32'(level), 16);
        chk("drop_count", 32'(drop_count), 1);
        chk("drop_overflow", 32'(overflow), 1);
        chk("drop_stalled_w0", bus.tr_data, 32'h80000000);

        // advance to beat 3 of the head, then retire while popping at full
        drv(1, 0, 0, 0, 0, 0, 0, 1);
        step();
        step();
        step();
        chk("full_beat3_last", 32'(bus.tr_last), 1);
        drv(1, 1, 0, 32'h200, 32'h17, 0, 32'h17, 1);
        step();
        chk("fullpop_level", 32'(level), 16);
        chk("fullpop_drops", 32'(drop_count), 1);
        chk("fullpop_next_w0", bus.tr_data, 32'h80000001);

        // drain everything and check the record sequence
        begin
            bit done = 0;
            drv(1, 0, 0, 0, 0, 0, 0, 1);
            for (int c = 0; c < 200 && !done; c++) begin
                if (bus.tr_valid) begin
                    wq.push_back(bus.tr_data);
                    lq.push_back(bus.tr_last);
                end
                step();
                if (level == 0 && !bus.tr_valid) done = 1;
            end
            chk("drain_done", 32'(done), 1);
        end
        chk("drain_words", wq.size(), 64);
        for (int r = 0; r < 16; r++) begin
            int          s;
            logic [31:0] e0;
            s  = (r < 15) ? r + 1 : 17;
            e0 = 32'h80000000 | 32'(s) | ((r == 15) ? 32'h08000000 : 32'h0);
            if (r * 4 + 3 < wq.size()) begin
                chk($sformatf("rec%0d_w0", r), wq[r*4], e0);
                chk($sformatf("rec%0d_pc", r), wq[r*4+1], (r < 15) ? 32'h100 + 32'(s) : 32'h200);
                chk($sformatf("rec%0d_last_w2", r), 32'(lq[r*4+2]), 0);
                chk($sformatf("rec%0d_last_w3", r), 32'(lq[r*4+3]), 1);
            end
        end
        chk("post_drain_overflow", 32'(overflow), 1);
        chk("post_drain_drops", 32'(drop_count), 1);
        chk("post_drain_freeze", 32'(freeze), 0);

        // ---------------- reset mid-record ----------------
        for (int i = 0; i < 3; i++) begin
            drv(1, 1, 0, 32'h300 + 32'(i), 32'hA0 + 32'(i), 0, 0, 0);
            step();
        end
        drv(1, 0, 0, 0, 0, 0, 0, 1);
        step();
        step();
        chk("mid_beat2_data", bus.tr_data, 32'hA0);
        chk("mid_level", 32'(level), 3);
        reset = 1'b0;
        step();
        chk("mid_rst_valid", 32'(bus.tr_valid), 0);
        chk("mid_rst_last", 32'(bus.tr_last), 0);
        chk("mid_rst_level", 32'(level), 0);
        chk("mid_rst_freeze", 32'(freeze), 0);
        chk("mid_rst_overflow", 32'(overflow), 0);
        chk("mid_rst_drops", 32'(drop_count), 0);
        reset = 1'b1;
        drv(1, 1, 0, 32'h400, 32'h1, 0, 0, 1);
        step();
        drv(1, 0, 0, 0, 0, 0, 0, 1);
        step();
        chk("after_rst_valid", 32'(bus.tr_valid), 1);
        chk("after_rst_w0", bus.tr_data, 32'h80000000);
        step();
        chk("after_rst_pc", bus.tr_data, 32'h400);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
